dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store from the memory
// stage, stalls it for LATENCY cycles, then completes with data or a fault pulse.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        ErrM
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  count, count_next;
  logic [31:0] addr_q, data_q;
  logic        wr_q;
  logic [31:0] mem [0:DEPTH-1];

  logic          req;
  logic          cur_wr;
  logic [31:0]   cur_addr, cur_data;
  logic [AW-1:0] idx;
  logic          fault;
  logic          finish;

  assign req = MemWriteM | MemtoRegM;

  // With LATENCY=1 the request completes on the edge that accepts it, so the
  // live inputs stand in for the captured copy while still in IDLE.
  assign cur_wr   = (state == IDLE) ? MemWriteM  : wr_q;
  assign cur_addr = (state == IDLE) ? ALUResultM : addr_q;
  assign cur_data = (state == IDLE) ? WriteDataM : data_q;

  assign idx    = cur_addr[AW+1:2];
  assign fault  = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
  assign finish = (state_next == DONE);

  always_comb begin
    state_next = state;
    count_next = count;
    StallM     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          StallM     = 1'b1;
          count_next = 3'(LATENCY - 1);
          state_next = (LATENCY > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        StallM     = 1'b1;
        count_next = count - 3'd1;
        if (count <= 3'd1) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 3'd0;
      ReadDataM <= 32'h0;
      ErrM      <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      ErrM  <= finish && fault;
      if (finish && !cur_wr) ReadDataM <= fault ? 32'h0 : mem[idx];
    end
  end

  // Captured request and storage carry no reset; only control is reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      wr_q   <= MemWriteM;
      addr_q <= ALUResultM;
      data_q <= WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && finish && cur_wr && !fault) mem[idx] <= cur_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for the main
// scenarios, LATENCY=1 instance for held back-to-back requests.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, ErrM;

  logic        w1, r1;
  logic [31:0] a1, d1, rd1;
  logic        st1, er1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl  [0:63];
  bit          mval [0:63];
  logic [31:0] rd_model;
  bit          rd_known;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .ErrM(ErrM)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .MemWriteM(w1), .MemtoRegM(r1),
    .ALUResultM(a1), .WriteDataM(d1),
    .ReadDataM(rd1), .StallM(st1), .ErrM(er1)
  );

  function automatic bit m_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
  endfunction

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   i;
    bit   f;
    f     = m_fault(addr);
    i     = int'(addr[7:2]);
    e.err = f;
    if (wr) begin
      if (!f) begin
        mdl[i]  = data;
        mval[i] = 1'b1;
      end
    end else if (f) begin
      rd_model = 32'h0;
      rd_known = 1'b1;
    end else if (mval[i]) begin
      rd_model = mdl[i];
      rd_known = 1'b1;
    end else begin
      rd_known = 1'b0;
    end
    e.data = rd_model;
    e.chk  = rd_known;
    sb.push_back(e);
  endtask

  // Drives one access in an IDLE cycle and consumes its scoreboard entry at completion.
  task automatic access(input string nm, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data, input bit scramble);
    exp_t e;
    int   stalls;
    int   err_early;
    @(negedge clk);
    MemWriteM  = wr;
    MemtoRegM  = rd;
    ALUResultM = addr;
    WriteDataM = data;
    push_exp(wr, addr, data);
    #1;
    stalls    = 0;
    err_early = 0;
    while (StallM === 1'b1 && stalls < 20) begin
      stalls++;
      if (ErrM !== 1'b0) err_early++;
      @(negedge clk);
      if (scramble) begin
        ALUResultM = $urandom;
        WriteDataM = $urandom;
      end
      #1;
    end
    e = sb.pop_front();
    total++;
    if (stalls != LAT) begin
      bad++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stalls, LAT);
    end
    total++;
    if (ErrM !== e.err || err_early != 0) begin
      bad++;
      $display("FAIL %s err got=%b (early=%0d) exp=%b", nm, ErrM, err_early, e.err);
    end
    if (e.chk) begin
      total++;
      if (ReadDataM !== e.data) begin
        bad++;
        $display("FAIL %s rdata got=%h exp=%h", nm, ReadDataM, e.data);
      end
    end
    MemWriteM = 1'b0;
    MemtoRegM = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (ErrM !== 1'b0 || StallM !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done err=%b stall=%b exp 0/0", nm, ErrM, StallM);
    end
  endtask

  task automatic test_reset();
    total++;
    if (ReadDataM !== 32'h0 || ErrM !== 1'b0 || StallM !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdata=%h err=%b stall=%b exp 0/0/0", ReadDataM, ErrM, StallM);
    end
    MemtoRegM = 1'b1;
    #1;
    total++;
    if (StallM !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle_stall got=%b exp=1", StallM);
    end
    MemtoRegM = 1'b0;
    #1;
    total++;
    if (st1 !== 1'b0 || rd1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_dut1 stall=%b rdata=%h exp 0/0", st1, rd1);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    access("wr_10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    access("rd_10", 1'b0, 1'b1, 32'h10, 32'h0, 1'b1);
    access("wr_fc", 1'b1, 1'b0, 32'hFC, 32'hA5A50001, 1'b1);
    access("rd_fc", 1'b0, 1'b1, 32'hFC, 32'h0, 1'b1);
    access("wr_00", 1'b1, 1'b0, 32'h0, 32'h00000077, 1'b0);
    access("rd_00", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    access("rd_10b", 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned();
    access("rd_12_mis", 1'b0, 1'b1, 32'h12, 32'h0, 1'b0);
    access("wr_13_mis", 1'b1, 1'b0, 32'h13, 32'hBAD0BAD0, 1'b0);
    access("rd_10_ok", 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_out_of_range();
    access("wr_100_oor", 1'b1, 1'b0, 32'h100, 32'h5A5A5A5A, 1'b0);
    access("rd_00_alias", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    access("rd_big_oor", 1'b0, 1'b1, 32'h40000000, 32'h0, 1'b0);
    access("rd_fc_again", 1'b0, 1'b1, 32'hFC, 32'h0, 1'b0);
  endtask

  task automatic test_both_high();
    access("both_08", 1'b1, 1'b1, 32'h8, 32'h00001234, 1'b1);
    access("rd_08", 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
  endtask

  task automatic test_reset_abort();
    access("wr_04", 1'b1, 1'b0, 32'h4, 32'h00000011, 1'b0);
    access("rd_04", 1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
    @(negedge clk);
    MemWriteM  = 1'b1;
    ALUResultM = 32'h4;
    WriteDataM = 32'hFFFF0000;
    @(negedge clk);
    reset = 1'b0;
    #1;
    MemWriteM = 1'b0;
    #1;
    total++;
    if (StallM !== 1'b0 || ReadDataM !== 32'h0 || ErrM !== 1'b0) begin
      bad++;
      $display("FAIL abort_state stall=%b rdata=%h err=%b exp 0/0/0", StallM, ReadDataM, ErrM);
    end
    @(negedge clk);
    reset    = 1'b1;
    rd_model = 32'h0;
    rd_known = 1'b1;
    access("rd_04_after_abort", 1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    w1 = 1'b1; r1 = 1'b0; a1 = 32'h20; d1 = 32'hCAFEF00D;
    #1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (st1 !== (k % 2 == 0) || er1 !== 1'b0) begin
        bad++;
        $display("FAIL b2b_wr cyc=%0d stall=%b err=%b exp stall=%b err=0", k, st1, er1, (k % 2 == 0));
      end
      @(negedge clk);
    end
    w1 = 1'b0; r1 = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (st1 !== (k % 2 == 0) || (k % 2 == 1 && rd1 !== 32'hCAFEF00D)) begin
        bad++;
        $display("FAIL b2b_rd cyc=%0d stall=%b rdata=%h exp stall=%b rdata=cafef00d", k, st1, rd1, (k % 2 == 0));
      end
      @(negedge clk);
    end
    a1 = 32'h21;
    #1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (st1 !== (k % 2 == 0) || er1 !== (k % 2 == 1) || (k % 2 == 1 && rd1 !== 32'h0)) begin
        bad++;
        $display("FAIL b2b_err cyc=%0d stall=%b err=%b rdata=%h exp stall=%b err=%b rdata=0",
                 k, st1, er1, rd1, (k % 2 == 0), (k % 2 == 1));
      end
      @(negedge clk);
    end
    r1 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
    w1 = 1'b0; r1 = 1'b0; a1 = 32'h0; d1 = 32'h0;
    rd_model = 32'h0;
    rd_known = 1'b1;
    for (int i = 0; i < 64; i++) mval[i] = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_both_high();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
